alu_operand_loader: RTL and testbench

Upstream feeder for the vector ALU. Accepts scalar operand pairs one element per cycle over a valid/ready handshake and packs `n_alu` of them into the wide `a`/`b` lane vectors. It presents each completed vector to the ALU together with its `select` opcode, using `enable` as the valid qualifier and `alu_ready` as backpressure. It also supports flush and counts issued vectors.

---
 rtl/alu_operand_loader.sv | 175 +++++++++++++++++
 tb/tb_alu_operand_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: packs n_alu scalar operand pairs, accepted one per cycle
// over valid/ready, into wide a/b lane vectors and presents each completed
// vector to the vector ALU with its select opcode (enable/alu_ready handshake).
// Counts transferred vectors modulo 256; flush discards partial and pending work.
//
// Optional feature macro: ALU_LOADER_PINGPONG_EN
//   defined   - the assembly buffer keeps filling as a shadow vector while the
//               output vector waits for the ALU (one vector per n_alu cycles).
//   undefined - single buffer; in_ready drops while a vector is being issued.
module alu_operand_loader #(
    parameter int WIDTH = 4,
    parameter int n_alu = 4,
    parameter int SEL_W = 3
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [SEL_W-1:0]             in_sel,
    input  logic                         flush,
    output logic [WIDTH*n_alu-1:0]       a,
    output logic [WIDTH*n_alu-1:0]       b,
    output logic [SEL_W-1:0]             select,
    output logic                         enable,
    input  logic                         alu_ready,
    output logic [$clog2(n_alu+1)-1:0]   fill_level,
    output logic [7:0]                   vec_count
);

    localparam int LVL_W = $clog2(n_alu + 1);
    localparam int VEC_W = WIDTH * n_alu;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               transfer;
    logic               last_lane;
    logic               complete;
    logic               load_out;
    logic [VEC_W-1:0]   fill_a;
    logic [VEC_W-1:0]   fill_b;
    logic [VEC_W-1:0]   fill_a_nx;
    logic [VEC_W-1:0]   fill_b_nx;
    logic [SEL_W-1:0]   fill_sel;
`ifdef ALU_LOADER_PINGPONG_EN
    logic               shadow_full;
`endif

    // State register: reset and flush both return to FILL.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values no matter how the always blocks are ordered.
        if (arst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake decode and next-state selection.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nx  = state;
        load_out  = 1'b0;
        enable    = (state == ISSUE);
`ifdef ALU_LOADER_PINGPONG_EN
        in_ready  = !arst && !flush && ((state == FILL) || !shadow_full);
`else
        in_ready  = !arst && !flush && (state == FILL);
`endif
        accept    = in_valid && in_ready;
        transfer  = enable && alu_ready && !flush;
        last_lane = (fill_level == LVL_W'(n_alu - 1));
        complete  = accept && last_lane;

        if (flush) begin
            state_nx = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (complete) begin
                        state_nx = ISSUE;
                        load_out = 1'b1;
                    end
                end
                ISSUE: begin
                    if (transfer) begin
`ifdef ALU_LOADER_PINGPONG_EN
                        // A finished shadow vector replaces the departing one.
                        if (shadow_full || complete) begin
                            load_out = 1'b1;
                        end else begin
                            state_nx = FILL;
                        end
`else
                        state_nx = FILL;
`endif
                    end
                end
                default: state_nx = FILL;
            endcase
        end
    end

    // Merge the accepted element into the lane selected by fill_level.
    always_comb begin
        fill_a_nx = fill_a;
        fill_b_nx = fill_b;
        for (int k = 0; k < n_alu; k++) begin
            if (accept && (fill_level == LVL_W'(k))) begin
                fill_a_nx[k*WIDTH +: WIDTH] = in_a;
                fill_b_nx[k*WIDTH +: WIDTH] = in_b;
            end
        end
    end

    // Assembly buffer lanes.
    always_ff @(posedge clk) begin
        // NOTE: the lane storage has no reset: every lane is rewritten before a
        // completed vector is loaded from it, so stale contents never escape.
        fill_a <= fill_a_nx;
        fill_b <= fill_b_nx;
    end

    // Fill index, lane-0 opcode capture, output vector and transfer counter.
    always_ff @(posedge clk) begin
        if (arst) begin
            fill_level <= '0;
            fill_sel   <= '0;
            a          <= '0;
            b          <= '0;
            select     <= '0;
            vec_count  <= '0;
        end else begin
            if (flush) begin
                fill_level <= '0;
            end else if (accept) begin
                fill_level <= last_lane ? '0 : fill_level + LVL_W'(1);
            end
            if (accept && (fill_level == '0)) begin
                fill_sel <= in_sel;
            end
            if (load_out) begin
                a      <= fill_a_nx;
                b      <= fill_b_nx;
                select <= fill_sel;
            end
            if (transfer) begin
                vec_count <= vec_count + 8'd1;
            end
        end
    end

`ifdef ALU_LOADER_PINGPONG_EN
    // Shadow vector complete and waiting behind the vector on the outputs.
    always_ff @(posedge clk) begin
        if (arst || flush) begin
            shadow_full <= 1'b0;
        end else if ((state == ISSUE) && complete && !transfer) begin
            shadow_full <= 1'b1;
        end else if (transfer) begin
            shadow_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based behavioural model of the loader.
module tb_alu_operand_loader;

    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int SEL_W = 3;
    localparam int LVL_W = $clog2(N + 1);
    localparam int VEC_W = WIDTH * N;
`ifdef ALU_LOADER_PINGPONG_EN
    localparam int CAP    = 2;
    localparam int PERIOD = N;
`else
    localparam int CAP    = 1;
    localparam int PERIOD = N + 1;
`endif

    logic               clk = 1'b0;
    logic               arst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [SEL_W-1:0]   in_sel;
    logic               flush;
    logic [VEC_W-1:0]   a;
    logic [VEC_W-1:0]   b;
    logic [SEL_W-1:0]   select;
    logic               enable;
    logic               alu_ready;
    logic [LVL_W-1:0]   fill_level;
    logic [7:0]         vec_count;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    alu_operand_loader #(
        .WIDTH (WIDTH),
        .n_alu (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .select     (select),
        .enable     (enable),
        .alu_ready  (alu_ready),
        .fill_level (fill_level),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [VEC_W-1:0] a;
        logic [VEC_W-1:0] b;
        logic [SEL_W-1:0] sel;
    } vec_t;

    vec_t             outq[$];
    logic [WIDTH-1:0] lane_a[$];
    logic [WIDTH-1:0] lane_b[$];
    logic [SEL_W-1:0] lane_sel = '0;
    int               m_count  = 0;
    int               m_acc    = 0;
    int               m_xfers  = 0;
    logic             m_acc_now;
    vec_t             m_v;

    function automatic logic m_in_ready();
        return !arst && !flush && (outq.size() < CAP);
    endfunction

    always @(posedge clk) begin
        if (arst) begin
            outq.delete();
            lane_a.delete();
            lane_b.delete();
            m_count = 0;
        end else if (flush) begin
            outq.delete();
            lane_a.delete();
            lane_b.delete();
        end else begin
            m_acc_now = in_valid && m_in_ready();
            if (outq.size() > 0 && alu_ready) begin
                outq.delete(0);
                m_count = (m_count + 1) % 256;
                m_xfers++;
            end
            if (m_acc_now) begin
                if (lane_a.size() == 0) lane_sel = in_sel;
                lane_a.push_back(in_a);
                lane_b.push_back(in_b);
                m_acc++;
                if (lane_a.size() == N) begin
                    m_v.a = '0;
                    m_v.b = '0;
                    for (int k = 0; k < N; k++) begin
                        m_v.a[k*WIDTH +: WIDTH] = lane_a[k];
                        m_v.b[k*WIDTH +: WIDTH] = lane_b[k];
                    end
                    m_v.sel = lane_sel;
                    outq.push_back(m_v);
                    lane_a.delete();
                    lane_b.delete();
                end
            end
        end
    end

    // Compare DUT against the model on the falling edge of every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, m_in_ready());
            check("enable", enable, outq.size() > 0);
            check("fill_level", fill_level, lane_a.size());
            check("vec_count", vec_count, m_count);
            if (outq.size() > 0) begin
                check("a", a, outq[0].a);
                check("b", b, outq[0].b);
                check("select", select, outq[0].sel);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                        input logic [SEL_W-1:0] es);
        in_valid = 1'b1;
        in_a     = ea;
        in_b     = eb;
        in_sel   = es;
        cyc();
        in_valid = 1'b0;
    endtask

    int en_t[6];
    int n_en;
    int t;
    int acc0;
    int x0;

    initial begin
        arst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0;
        flush = 1'b0; alu_ready = 1'b0;
        cyc();
        cyc();
        cmp_en = 1'b1;

        // Reset values
        check("rst_a", a, 16'h0);
        check("rst_b", b, 16'h0);
        check("rst_select", select, 3'd0);
        check("rst_enable", enable, 1'b0);
        check("rst_fill_level", fill_level, 0);
        check("rst_vec_count", vec_count, 8'd0);
        check("rst_in_ready", in_ready, 1'b0);
        arst = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);

        // Pack order
        alu_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) check("pack_enable_early", enable, 1'b0);
            send(WIDTH'(i + 1), WIDTH'(15 - i), (i == 0) ? 3'd2 : 3'd5);
        end
        check("pack_enable", enable, 1'b1);
        check("pack_a", a, 16'h4321);
        check("pack_b", b, 16'hCDEF);
        check("pack_select", select, 3'd2);
        check("pack_count_before", vec_count, 8'd0);
        cyc();
        check("pack_enable_one_cycle", enable, 1'b0);
        check("pack_count", vec_count, 8'd1);

        // Backpressure
        alu_ready = 1'b0;
        send(4'h5, 4'h0, 3'd7); send(4'h6, 4'h1, 3'd0);
        send(4'h7, 4'h2, 3'd0); send(4'h8, 4'h3, 3'd0);
        for (int c = 0; c < 5; c++) begin
            check("bp_enable", enable, 1'b1);
            check("bp_a", a, 16'h8765);
            check("bp_b", b, 16'h3210);
            check("bp_select", select, 3'd7);
            check("bp_in_ready", in_ready, (CAP == 1) ? 1'b0 : 1'b1);
            cyc();
        end
        check("bp_count_held", vec_count, 8'd1);
        alu_ready = 1'b1;
        cyc();
        check("bp_enable_after", enable, 1'b0);
        check("bp_count", vec_count, 8'd2);
        check("bp_in_ready_after", in_ready, 1'b1);

        // Flush mid-fill, then flush during issue
        send(4'h9, 4'h9, 3'd1); send(4'h9, 4'h9, 3'd1); send(4'h9, 4'h9, 3'd1);
        check("fl_fill_level_3", fill_level, 3'd3);
        flush = 1'b1; in_valid = 1'b1; in_a = 4'hA;
        #1;
        check("fl_in_ready", in_ready, 1'b0);
        cyc();
        check("fl_fill_level_0", fill_level, 3'd0);
        flush = 1'b0; in_valid = 1'b0;
        send(4'hC, 4'h1, 3'd3); send(4'hD, 4'h2, 3'd0);
        send(4'hE, 4'h3, 3'd0); send(4'hF, 4'h4, 3'd0);
        check("fl_enable", enable, 1'b1);
        check("fl_a", a, 16'hFEDC);
        check("fl_b", b, 16'h4321);
        check("fl_select", select, 3'd3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fl_issue_enable", enable, 1'b0);
        check("fl_issue_count", vec_count, 8'd2);

        // Reset mid-operation
        send(4'h3, 4'h3, 3'd1); send(4'h3, 4'h3, 3'd1);
        arst = 1'b1; in_valid = 1'b1; in_a = 4'h7;
        #1;
        check("mr_in_ready", in_ready, 1'b0);
        cyc();
        check("mr_a", a, 16'h0);
        check("mr_b", b, 16'h0);
        check("mr_select", select, 3'd0);
        check("mr_enable", enable, 1'b0);
        check("mr_fill_level", fill_level, 3'd0);
        check("mr_count", vec_count, 8'd0);
        cyc();
        check("mr_in_ready2", in_ready, 1'b0);
        arst = 1'b0; in_valid = 1'b0;
        #1;
        check("mr_in_ready_release", in_ready, 1'b1);
        send(4'h1, 4'h5, 3'd4); send(4'h2, 4'h6, 3'd0);
        send(4'h3, 4'h7, 3'd0); send(4'h4, 4'h8, 3'd0);
        check("mr_pack_a", a, 16'h4321);
        check("mr_pack_b", b, 16'h8765);
        check("mr_pack_select", select, 3'd4);
        cyc();
        check("mr_pack_count", vec_count, 8'd1);

        // Wrap and throughput: 256 vectors on a continuous stream
        arst = 1'b1;
        cyc();
        arst = 1'b0;
        acc0 = m_acc; x0 = m_xfers; t = 0; n_en = 0;
        in_valid = 1'b1;
        while ((m_acc - acc0) < 256 * N && t < 4000) begin
            in_a   = WIDTH'($urandom);
            in_b   = WIDTH'($urandom);
            in_sel = SEL_W'($urandom);
            cyc();
            t++;
            if (enable && n_en < 6) begin
                en_t[n_en] = t;
                n_en++;
            end
        end
        in_valid = 1'b0;
        check("wrap_accepts", m_acc - acc0, 256 * N);
        repeat (4) cyc();
        check("wrap_model_xfers", m_xfers - x0, 256);
        check("wrap_count", vec_count, 8'd0);
        check("wrap_enable", enable, 1'b0);
        check("tput_samples", n_en, 6);
        for (int i = 1; i < 6; i++) begin
            check("tput_period", en_t[i] - en_t[i-1], PERIOD);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = WIDTH'($urandom);
            in_b      = WIDTH'($urandom);
            in_sel    = SEL_W'($urandom);
            alu_ready = (i < 1500) ? ($urandom_range(2) != 0) : ($urandom_range(3) == 0);
            flush     = ($urandom_range(49) == 0);
            arst      = ($urandom_range(299) == 0);
            cyc();
        end

        in_valid = 1'b0; flush = 1'b0; arst = 1'b0; alu_ready = 1'b1;
        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
